// File: rtl/cpu_mux_pkg.sv
// Shared definitions for the CPU datapath channel merger (mux_arb_n).
// Holds the channel-count ceiling and the rotate-and-find-first-set
// search used by the grant picker.
package cpu_mux_pkg;

    localparam int MUX_MAX_CH = 16;
    localparam int MUX_IDX_W  = 4;

    // Returns {found, index}. Scans channels start, start+1, ... modulo n
    // and reports the first one whose request bit is set. start must be < n.
    function automatic logic [MUX_IDX_W:0] rr_find_first(
        input logic [MUX_MAX_CH-1:0] req,
        input logic [MUX_IDX_W-1:0]  start,
        input logic [MUX_IDX_W:0]    n
    );
        logic                 found;
        logic [MUX_IDX_W-1:0] idx;
        logic [MUX_IDX_W:0]   pos;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < MUX_MAX_CH; k++) begin
            pos = {1'b0, start} + (MUX_IDX_W+1)'(k);
            if (pos >= n) begin
                pos = pos - n;
            end
            if (!found && ((MUX_IDX_W+1)'(k) < n) && req[pos[MUX_IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = pos[MUX_IDX_W-1:0];
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/mux_arb_rr_pick.sv
// Combinational grant picker: given per-channel requests and a start
// pointer, returns the first requesting channel at or after the pointer
// (wrapping) and a flag saying whether any channel was found.
module mux_arb_rr_pick
    import cpu_mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
)(
    input  logic [NUM_CH-1:0] i_req,
    input  logic [SEL_W-1:0]  i_start,
    output logic [SEL_W-1:0]  o_grant,
    output logic              o_found
);

    logic [MUX_MAX_CH-1:0] w_req;
    logic [MUX_IDX_W-1:0]  w_start;
    logic [MUX_IDX_W:0]    w_res;

    // Widen requests and pointer to the package search width, then search.
    always_comb begin
        w_req                = '0;
        w_req[NUM_CH-1:0]    = i_req;
        w_start              = '0;
        w_start[SEL_W-1:0]   = i_start;
        w_res                = rr_find_first(w_req, w_start, (MUX_IDX_W+1)'(NUM_CH));
    end

    assign o_found = w_res[MUX_IDX_W];
    assign o_grant = SEL_W'(w_res[MUX_IDX_W-1:0]);

endmodule

// File: rtl/mux_arb_n.sv
// mux_arb_n: merges NUM_CH valid/ready channels onto one registered
// output stream. Arbitration mode picks a requester; forced mode behaves
// like a registered plain mux on force_sel.
// Build option MUX_ARB_RR_EN: defined -> round-robin grant with rr_ptr;
// undefined -> fixed priority, lowest requesting index wins.
//
// Handshake: a word moves when valid && ready are both high at a rising
// edge; valid never waits on ready, and a producer holding valid keeps its
// data stable until accepted. The output register may accept a new word
// whenever it is empty or being drained in the same cycle (load_ok), which
// gives one word per cycle at full throughput.
module mux_arb_n
    import cpu_mux_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = $clog2(NUM_CH)
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic                    force_en,
    input  logic [SEL_W-1:0]        force_sel,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    input  logic                    out_ready
);

    logic              r_out_valid;
    logic [WIDTH-1:0]  r_out_data;
    logic [SEL_W-1:0]  r_out_sel;

    logic              w_load_ok;
    logic [SEL_W-1:0]  w_start;
    logic [SEL_W-1:0]  w_pick_grant;
    logic              w_pick_found;
    logic              w_force_valid;
    logic [SEL_W-1:0]  w_grant;
    logic              w_grant_vld;
    logic              w_xfer;
    logic [WIDTH-1:0]  w_sel_data;

    assign w_load_ok = !r_out_valid || out_ready;

`ifdef MUX_ARB_RR_EN
    logic [SEL_W-1:0]  r_rr_ptr;

    // Pointer advances past the channel just served; forced-mode transfers
    // leave it alone so arbitration resumes where it left off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_xfer && !force_en) begin
            r_rr_ptr <= (w_grant == SEL_W'(NUM_CH-1)) ? '0 : w_grant + SEL_W'(1);
        end
    end

    assign w_start = r_rr_ptr;
`else
    assign w_start = '0;
`endif

    mux_arb_rr_pick #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_pick (
        .i_req   (in_valid),
        .i_start (w_start),
        .o_grant (w_pick_grant),
        .o_found (w_pick_found)
    );

    // Forced channel is eligible only if it exists and is requesting;
    // an out-of-range force_sel matches no channel and grants nothing.
    always_comb begin
        w_force_valid = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (force_sel == SEL_W'(i)) begin
                w_force_valid = in_valid[i];
            end
        end
    end

    // Grant selection depends only on in_valid, the pointer and the mode.
    always_comb begin
        w_grant     = '0;
        w_grant_vld = 1'b0;
        if (force_en) begin
            w_grant     = force_sel;
            w_grant_vld = w_force_valid;
        end else begin
            w_grant     = w_pick_grant;
            w_grant_vld = w_pick_found;
        end
    end

    assign w_xfer = rst_n && w_load_ok && w_grant_vld;

    // One-hot accept for the granted channel, all zero when no transfer.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            in_ready[i] = w_xfer && (w_grant == SEL_W'(i));
        end
    end

    // Data mux for the granted channel.
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_grant == SEL_W'(i)) begin
                w_sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output register: load on transfer (even while draining), clear on a
    // drain with nothing new, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_sel   <= w_grant;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed bench for mux_arb_n (4 channels, plus a 5-channel instance for
// out-of-range forced selects). Expectations follow the MUX_ARB_RR_EN build
// option: round-robin when defined, fixed priority otherwise.
module tb_mux_arb_n;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int SW = 2;

`ifdef MUX_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           force_en;
    logic [SW-1:0]  force_sel;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_sel;
    logic           out_ready;

    logic [4:0]     in_valid5;
    logic [5*W-1:0] in_data5;
    logic [4:0]     in_ready5;
    logic           force_en5;
    logic [2:0]     force_sel5;
    logic           out_valid5;
    logic [W-1:0]   out_data5;
    logic [2:0]     out_sel5;
    logic           out_ready5;

    int n_vec = 0;
    int n_err = 0;

    mux_arb_n #(.WIDTH(W), .NUM_CH(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .force_en  (force_en),
        .force_sel (force_sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    mux_arb_n #(.WIDTH(W), .NUM_CH(5)) dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid5),
        .in_data   (in_data5),
        .in_ready  (in_ready5),
        .force_en  (force_en5),
        .force_sel (force_sel5),
        .out_valid (out_valid5),
        .out_data  (out_data5),
        .out_sel   (out_sel5),
        .out_ready (out_ready5)
    );

    // driver tasks
    task automatic next();
        @(posedge clk);
        #2;
    endtask

    task automatic set_ch(input int i, input logic [W-1:0] d);
        in_data[i*W +: W] = d;
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // checker
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        in_valid   = '0;
        in_data    = '0;
        force_en   = 1'b0;
        force_sel  = '0;
        out_ready  = 1'b0;
        in_valid5  = '0;
        in_data5   = '0;
        force_en5  = 1'b0;
        force_sel5 = '0;
        out_ready5 = 1'b0;

        // reset state
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sel", out_sel, 0);
        in_valid = 4'b1111;
        #1;
        chk("rst_in_ready", in_ready, 0);
        in_valid = '0;

        // all channels valid, continuous drain
        next();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) set_ch(i, 32'h1000 + i);
        in_valid = 4'b1111;
        #1;
        chk("all_ready0", in_ready, 4'b0001);
        for (int k = 0; k < 6; k++) begin
            next();
            #1;
            chk("all_valid", out_valid, 1);
            chk("all_sel", out_sel, RR ? (k % 4) : 0);
            chk("all_data", out_data, RR ? (32'h1000 + (k % 4)) : 32'h1000);
            chk("all_ready", in_ready, RR ? onehot((k + 1) % 4) : 4'b0001);
        end
        in_valid = '0;
        next();
        #1;
        chk("all_drain", out_valid, 0);

        // sparse single-cycle pulse on ch2
        set_ch(2, 32'h2222_2222);
        in_valid = 4'b0100;
        #1;
        chk("sparse_ready", in_ready, 4'b0100);
        chk("sparse_pre_valid", out_valid, 0);
        next();
        in_valid = '0;
        #1;
        chk("sparse_valid", out_valid, 1);
        chk("sparse_sel", out_sel, 2);
        chk("sparse_data", out_data, 32'h2222_2222);
        chk("sparse_idle_ready", in_ready, 0);
        next();
        #1;
        chk("sparse_drop", out_valid, 0);

        // pointer wrap: ch3 and ch0 valid
        set_ch(3, 32'h3333_3333);
        set_ch(0, 32'hC0C0_C0C0);
        in_valid = 4'b1001;
        #1;
        chk("wrap_ready0", in_ready, RR ? 4'b1000 : 4'b0001);
        next();
        #1;
        chk("wrap_sel0", out_sel, RR ? 3 : 0);
        chk("wrap_data0", out_data, RR ? 32'h3333_3333 : 32'hC0C0_C0C0);
        chk("wrap_ready1", in_ready, 4'b0001);
        next();
        #1;
        chk("wrap_sel1", out_sel, 0);
        chk("wrap_data1", out_data, 32'hC0C0_C0C0);
        in_valid = 4'b1111;
        #1;
        chk("wrap_ptr_probe", in_ready, RR ? 4'b0010 : 4'b0001);
        in_valid = '0;
        next();
        #1;
        chk("wrap_drain", out_valid, 0);

        // backpressure with ch2 streaming
        set_ch(2, 32'hDEAD_BEEF);
        in_valid = 4'b0100;
        #1;
        chk("bp_ready0", in_ready, 4'b0100);
        next();
        out_ready = 1'b0;
        set_ch(2, 32'hBEEF_0001);
        #1;
        chk("bp_stall1_valid", out_valid, 1);
        chk("bp_stall1_data", out_data, 32'hDEAD_BEEF);
        chk("bp_stall1_sel", out_sel, 2);
        chk("bp_stall1_ready", in_ready, 0);
        next();
        force_en  = 1'b1;
        force_sel = 2'd2;
        #1;
        chk("bp_stall2_data", out_data, 32'hDEAD_BEEF);
        chk("bp_stall2_ready", in_ready, 0);
        next();
        force_en = 1'b0;
        #1;
        chk("bp_stall3_data", out_data, 32'hDEAD_BEEF);
        chk("bp_stall3_sel", out_sel, 2);
        chk("bp_stall3_ready", in_ready, 0);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 4'b0100);
        next();
        #1;
        chk("bp_reload_valid", out_valid, 1);
        chk("bp_reload_data", out_data, 32'hBEEF_0001);
        in_valid = '0;
        next();
        #1;
        chk("bp_drain", out_valid, 0);

        // forced select on ch1 with ch0/ch1/ch3 valid
        force_en  = 1'b1;
        force_sel = 2'd1;
        set_ch(0, 32'hA0A0_A0A0);
        set_ch(1, 32'h1111_0000);
        set_ch(3, 32'h3030_3030);
        in_valid = 4'b1011;
        #1;
        chk("force_ready0", in_ready, 4'b0010);
        for (int k = 0; k < 3; k++) begin
            next();
            set_ch(1, 32'h1111_0000 + k + 1);
            #1;
            chk("force_valid", out_valid, 1);
            chk("force_sel_out", out_sel, 1);
            chk("force_data", out_data, 32'h1111_0000 + k);
            chk("force_ready", in_ready, 4'b0010);
        end
        force_sel = 2'd2;
        #1;
        chk("force_idle_ch", in_ready, 0);
        in_valid = '0;
        force_en = 1'b0;
        next();
        #1;
        chk("force_drain", out_valid, 0);

        // out-of-range force_sel on the 5-channel instance
        in_valid5  = 5'b11111;
        force_en5  = 1'b1;
        force_sel5 = 3'd5;
        #1;
        chk("oor_sel5", in_ready5, 0);
        force_sel5 = 3'd7;
        #1;
        chk("oor_sel7", in_ready5, 0);
        force_sel5 = 3'd4;
        #1;
        chk("inr_sel4", in_ready5, 5'b10000);
        force_en5  = 1'b0;
        force_sel5 = 3'd0;
        #1;
        chk("n5_arb", in_ready5, 5'b00001);
        in_valid5 = '0;

        // reset in the middle of a held word
        next();
        set_ch(0, 32'hA5A5_A5A5);
        in_valid = 4'b0001;
        #1;
        chk("mid_ready", in_ready, 4'b0001);
        next();
        in_valid  = '0;
        out_ready = 1'b0;
        #1;
        chk("mid_valid", out_valid, 1);
        chk("mid_data", out_data, 32'hA5A5_A5A5);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_sel", out_sel, 0);
        in_valid = 4'b1111;
        #1;
        chk("mid_rst_ready", in_ready, 0);
        for (int i = 0; i < N; i++) set_ch(i, 32'h1000 + i);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("post_rst_ready", in_ready, 4'b0001);
        next();
        #1;
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_sel", out_sel, 0);
        chk("post_rst_data", out_data, 32'h1000);
        in_valid = '0;
        next();

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
